// File: rtl/display_arbiter.sv
// Two-requester owner arbiter for the 4-digit seven-segment display.
// B wins only from IDLE; an owner keeps the display for HOLD_CYCLES before a waiting rival takes over.
module display_arbiter #(
    parameter int          HOLD_CYCLES = 100_000_000,
    parameter logic [31:0] BLANK_WORD  = 32'h2020_2020
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        a_req,
    input  logic [31:0] a_value,
    output logic        a_grant,
    input  logic        b_req,
    input  logic [31:0] b_value,
    output logic        b_grant,
    output logic [31:0] display_values,
    output logic        busy
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_hold_cnt;
    logic            w_expired;
    logic            r_a_grant;
    logic            r_b_grant;
    logic            r_busy;
    logic [31:0]     r_disp;

    assign w_expired = (r_hold_cnt == CW'(HOLD_CYCLES - 1));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (b_req)      w_next = OWN_B;
                else if (a_req) w_next = OWN_A;
            end
            OWN_A: begin
                // Voluntary release ignores the hold time; forced handoff needs it expired.
                if (!a_req)                w_next = b_req ? OWN_B : IDLE;
                else if (b_req && w_expired) w_next = OWN_B;
            end
            OWN_B: begin
                if (!b_req)                w_next = a_req ? OWN_A : IDLE;
                else if (a_req && w_expired) w_next = OWN_A;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_hold_cnt <= '0;
            else if (r_state != IDLE && !w_expired)
                r_hold_cnt <= r_hold_cnt + CW'(1);
        end
    end

    // Outputs decode the next state so grant and the owner's value land on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_grant <= 1'b0;
            r_b_grant <= 1'b0;
            r_busy    <= 1'b0;
            r_disp    <= BLANK_WORD;
        end else begin
            r_a_grant <= (w_next == OWN_A);
            r_b_grant <= (w_next == OWN_B);
            r_busy    <= (w_next != IDLE);
            unique case (w_next)
                OWN_A:   r_disp <= a_value;
                OWN_B:   r_disp <= b_value;
                default: r_disp <= BLANK_WORD;
            endcase
        end
    end

    assign a_grant        = r_a_grant;
    assign b_grant        = r_b_grant;
    assign busy           = r_busy;
    assign display_values = r_disp;

endmodule
